// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the memory stage controller, the EXE/MEM pipeline side
// and the external 16-bit SRAM. The controller uses the slave modport; the
// environment (pipeline plus SRAM pins) uses the master modport.
interface mem_stage_sram_ctrl_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int SRAM_DATA_W = 16
);
  logic                   rd_en;
  logic                   wr_en;
  logic [WORD_WIDTH-1:0]  address;
  logic [WORD_WIDTH-1:0]  wr_data;
  logic [WORD_WIDTH-1:0]  rd_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_o;
  logic                   sram_dq_oe;
  logic [SRAM_DATA_W-1:0] sram_dq_i;
  logic                   sram_we_n;

  modport master (
    output rd_en, wr_en, address, wr_data, sram_dq_i,
    input  rd_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, wr_data, sram_dq_i,
    output rd_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data-memory controller. Splits each 32-bit load/store into a
// low and a high 16-bit SRAM access, holding ready low (pipeline freeze) until
// a one-cycle DONE state lets the pipeline advance.
//
// state | meaning
// IDLE  | no access; ready mirrors absence of a request; request latched here
// LOW   | half-word 2k on the bus for WAIT_CYCLES cycles
// HIGH  | half-word 2k+1 on the bus for WAIT_CYCLES cycles
// DONE  | single cycle with ready=1; load data valid; back to IDLE
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int SRAM_DATA_W = 16,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  mem_stage_sram_ctrl_if.slave bus
);

  localparam int HW    = SRAM_DATA_W;
  localparam int KW    = SRAM_ADDR_W - 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [KW-1:0]          k_q;
  logic [HW-1:0]          wdata_hi_q;
  logic                   op_wr_q;
  logic [WORD_WIDTH-1:0]  rd_data_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [HW-1:0]          sram_dq_o_q;
  logic                   sram_dq_oe_q;
  logic                   sram_we_n_q;

  logic                   req;
  logic [WORD_WIDTH-1:0]  addr_off;
  logic [KW-1:0]          k_in;
  logic                   unused_addr_bits;

  // Word index relative to the SRAM base; the subtraction wraps naturally and
  // the slice keeps only the bits that fit the half-word address space.
  assign req              = bus.rd_en | bus.wr_en;
  assign addr_off         = bus.address - WORD_WIDTH'(BASE_ADDR);
  assign k_in             = addr_off[SRAM_ADDR_W:2];
  assign unused_addr_bits = ^{addr_off[WORD_WIDTH-1:SRAM_ADDR_W+1], addr_off[1:0]};

  // ready is combinational only in IDLE so an idle pipeline sees zero added latency.
  assign bus.ready      = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign bus.rd_data    = rd_data_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_dq_o  = sram_dq_o_q;
  assign bus.sram_dq_oe = sram_dq_oe_q;
  assign bus.sram_we_n  = sram_we_n_q;

  // Access sequencer; SRAM strobes are registered so they only move on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      wdata_hi_q   <= '0;
      op_wr_q      <= 1'b0;
      rd_data_q    <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // A simultaneous rd_en/wr_en is treated as a store.
            k_q          <= k_in;
            wdata_hi_q   <= bus.wr_data[WORD_WIDTH-1:HW];
            op_wr_q      <= bus.wr_en;
            cnt_q        <= '0;
            state_q      <= LOW;
            sram_addr_q  <= {k_in, 1'b0};
            sram_dq_o_q  <= bus.wr_data[HW-1:0];
            sram_dq_oe_q <= bus.wr_en;
            sram_we_n_q  <= ~bus.wr_en;
          end
        end
        LOW: begin
          if (cnt_q == CNT_LAST) begin
            if (!op_wr_q) rd_data_q[HW-1:0] <= bus.sram_dq_i;
            cnt_q       <= '0;
            state_q     <= HIGH;
            sram_addr_q <= {k_q, 1'b1};
            sram_dq_o_q <= wdata_hi_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt_q == CNT_LAST) begin
            if (!op_wr_q) rd_data_q[WORD_WIDTH-1:HW] <= bus.sram_dq_i;
            cnt_q        <= '0;
            state_q      <= DONE;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: a table of load/store transactions
// against a behavioural SRAM, plus a hand-written reset-during-HIGH sequence.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  logic clk;
  logic rst;

  mem_stage_sram_ctrl_if #(.WORD_WIDTH(32), .SRAM_ADDR_W(18), .SRAM_DATA_W(16)) bus ();

  mem_stage_sram_ctrl #(
    .WORD_WIDTH(32), .SRAM_ADDR_W(18), .SRAM_DATA_W(16),
    .BASE_ADDR(1024), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: write while we_n is low at a clock edge, asynchronous read.
  logic [15:0] sram_mem [0:(1<<18)-1];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_o;
  end
  assign bus.sram_dq_i = sram_mem[bus.sram_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        scramble;
    int          exp_busy;
    int          exp_we;
    logic [17:0] exp_lo;
    logic [17:0] exp_hi;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  // Applies one request from IDLE (called just after a rising edge) and
  // returns just after the DONE edge so back-to-back calls have no gap.
  task automatic run_op(input vec_t v);
    int          busy = 0;
    int          we_cnt = 0;
    int          oe_cnt = 0;
    bit          done = 0;
    logic [17:0] lo_a = '0;
    logic [17:0] hi_a = '0;
    logic [31:0] rd_at_done = '0;
    bus.rd_en   = v.rd;
    bus.wr_en   = v.wr;
    bus.address = v.addr;
    bus.wr_data = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!bus.sram_we_n) we_cnt++;
      if (bus.sram_dq_oe) oe_cnt++;
      if (c == 1) lo_a = bus.sram_addr;
      if (c == 2 * W) hi_a = bus.sram_addr;
      if (bus.ready) begin
        done = 1;
        rd_at_done = bus.rd_data;
      end else begin
        busy++;
      end
      @(posedge clk);
      #1;
      if (v.scramble && c == 0) begin
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b1;
        bus.address = 32'd1032;
        bus.wr_data = 32'h0000_0000;
      end
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: ready never returned high", v.name);
    end else begin
      check({v.name, " busy"}, 32'(busy), 32'(v.exp_busy));
      check({v.name, " we_n low cycles"}, 32'(we_cnt), 32'(v.exp_we));
      check({v.name, " oe cycles"}, 32'(oe_cnt), 32'(v.exp_we));
      if (v.exp_busy > 0) begin
        check({v.name, " low addr"}, 32'(lo_a), 32'(v.exp_lo));
        check({v.name, " high addr"}, 32'(hi_a), 32'(v.exp_hi));
      end
      check({v.name, " rd_data"}, rd_at_done, v.exp_rd);
    end
  endtask

  initial begin
    //            name        rd    wr    addr          wdata         scr   busy we lo         hi         rd_data
    vecs[0]  = '{"idle",     1'b0, 1'b0, 32'd1032,     32'h0,        1'b0, 0, 0, 18'd0,     18'd0,     32'h0};
    vecs[1]  = '{"st1032",   1'b0, 1'b1, 32'd1032,     32'hDEADBEEF, 1'b0, 5, 4, 18'd4,     18'd5,     32'h0};
    vecs[2]  = '{"ld1032",   1'b1, 1'b0, 32'd1032,     32'h0,        1'b0, 5, 0, 18'd4,     18'd5,     32'hDEADBEEF};
    vecs[3]  = '{"st1040",   1'b0, 1'b1, 32'd1040,     32'hCAFEF00D, 1'b0, 5, 4, 18'd8,     18'd9,     32'hDEADBEEF};
    vecs[4]  = '{"ld1040",   1'b1, 1'b0, 32'd1040,     32'h0,        1'b0, 5, 0, 18'd8,     18'd9,     32'hCAFEF00D};
    vecs[5]  = '{"both1024", 1'b1, 1'b1, 32'd1024,     32'h12345678, 1'b0, 5, 4, 18'd0,     18'd1,     32'hCAFEF00D};
    vecs[6]  = '{"ld1026",   1'b1, 1'b0, 32'd1026,     32'h0,        1'b0, 5, 0, 18'd0,     18'd1,     32'h12345678};
    vecs[7]  = '{"ldwrap",   1'b1, 1'b0, 32'd525312,   32'h0,        1'b0, 5, 0, 18'd0,     18'd1,     32'h12345678};
    vecs[8]  = '{"st1020",   1'b0, 1'b1, 32'd1020,     32'hA5A55A5A, 1'b0, 5, 4, 18'h3FFFE, 18'h3FFFF, 32'h12345678};
    vecs[9]  = '{"ld1020",   1'b1, 1'b0, 32'd1020,     32'h0,        1'b0, 5, 0, 18'h3FFFE, 18'h3FFFF, 32'hA5A55A5A};
    vecs[10] = '{"ldscramb", 1'b1, 1'b0, 32'd1040,     32'h0,        1'b1, 5, 0, 18'd8,     18'd9,     32'hCAFEF00D};
    vecs[11] = '{"st1100",   1'b0, 1'b1, 32'd1100,     32'h22221111, 1'b0, 5, 4, 18'd38,    18'd39,    32'hCAFEF00D};

    rst         = 1'b1;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = '0;
    bus.wr_data = '0;

    @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset rd_data", bus.rd_data, 32'h0);
    check("reset sram_addr", 32'(bus.sram_addr), 32'h0);
    check("reset sram_dq_o", 32'(bus.sram_dq_o), 32'h0);
    check("reset oe", 32'(bus.sram_dq_oe), 32'd0);
    check("reset we_n", 32'(bus.sram_we_n), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    check("sram[4] low half", 32'(sram_mem[4]), 32'h0000BEEF);
    check("sram[5] high half", 32'(sram_mem[5]), 32'h0000DEAD);
    check("sram[0] both op", 32'(sram_mem[0]), 32'h00005678);

    // Reset pulse in the first HIGH cycle of a store to 1100 (halves 38/39).
    bus.wr_en   = 1'b1;
    bus.address = 32'd1100;
    bus.wr_data = 32'h87654321;
    repeat (W + W / W * 0 + 0) @(posedge clk);
    @(posedge clk);
    #1;
    check("pre-reset in HIGH addr", 32'(bus.sram_addr), 32'd39);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    check("midrst we_n", 32'(bus.sram_we_n), 32'd1);
    check("midrst oe", 32'(bus.sram_dq_oe), 32'd0);
    check("midrst ready", 32'(bus.ready), 32'd1);
    check("midrst sram_addr", 32'(bus.sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst sram[38] written", 32'(sram_mem[38]), 32'h00004321);
    check("midrst sram[39] kept", 32'(sram_mem[39]), 32'h00002222);

    run_op('{"ld1100", 1'b1, 1'b0, 32'd1100, 32'h0, 1'b0, 5, 0, 18'd38, 18'd39, 32'h22224321});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rd_data held idle", bus.rd_data, 32'h22224321);
    check("idle ready", 32'(bus.ready), 32'd1);
    check("idle we_n", 32'(bus.sram_we_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
